// File: rtl/sdiomux_hdx_serdes_if.sv
`default_nettype none
// ============================================================================
// Module      : sdiomux_hdx_serdes_if
// Description : Fabric handshake and SDIOMUX pad bundle for the half-duplex
//               single-wire serializer/deserializer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sdiomux_hdx_serdes_if #(
    parameter int WIDTH = 8
);
    // Fabric-side parallel interface
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             busy;
    // Pad-cell side (OQI/OE/IE toward SDIOMUX, IZ back from it)
    logic             oqi;
    logic             oe;
    logic             ie;
    logic             iz;

    // Environment: fabric producer/consumer plus the pad cell model
    modport master (
        output tx_data, tx_valid, iz,
        input  tx_ready, rx_data, rx_valid, busy, oqi, oe, ie
    );

    // The serdes itself
    modport slave (
        input  tx_data, tx_valid, iz,
        output tx_ready, rx_data, rx_valid, busy, oqi, oe, ie
    );
endinterface
`default_nettype wire

// File: rtl/sdiomux_hdx_serdes.sv
`default_nettype none
// ============================================================================
// Module      : sdiomux_hdx_serdes
// Description : Half-duplex single-wire serdes in front of an SDIOMUX pad.
//               Frames are one start bit (1) followed by WIDTH data bits,
//               MSB first. Every frame is followed by TURNAROUND dead cycles
//               with both OE and IE low so the pad never fights itself.
// Revision    : 1.0 - initial release
// ============================================================================
module sdiomux_hdx_serdes #(
    parameter int WIDTH       = 8,
    parameter int TURNAROUND  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    sdiomux_hdx_serdes_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TX   = 2'd1;
    localparam logic [1:0] S_RX   = 2'd2;
    localparam logic [1:0] S_TURN = 2'd3;

    // TX occupies WIDTH+1 cycles (start bit + data), RX samples WIDTH bits
    localparam logic [CW-1:0] TX_LAST   = CW'(WIDTH);
    localparam logic [CW-1:0] RX_LAST   = CW'(WIDTH - 1);
    localparam logic [3:0]    TURN_INIT = 4'(TURNAROUND);

    logic [SYNC_STAGES-1:0] sync;
    logic                   iz_s;

    logic [1:0]       state,    state_nxt;
    logic [CW-1:0]    bit_cnt,  bit_cnt_nxt;
    logic [3:0]       turn_cnt, turn_cnt_nxt;
    logic [WIDTH-1:0] shreg,    shreg_nxt;
    logic             oqi,      oqi_nxt;
    logic             oe,       oe_nxt;
    logic             ie,       ie_nxt;
    logic [WIDTH-1:0] rx_data,  rx_data_nxt;
    logic             rx_valid, rx_valid_nxt;

    // Resynchronise the asynchronous pad input before any logic looks at it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.iz};
        end
    end

    assign iz_s = sync[SYNC_STAGES-1];

    // State register plus registered pad controls and receive outputs
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= S_TURN;
            bit_cnt  <= '0;
            turn_cnt <= TURN_INIT;
            shreg    <= '0;
            oqi      <= 1'b0;
            oe       <= 1'b0;
            ie       <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            turn_cnt <= turn_cnt_nxt;
            shreg    <= shreg_nxt;
            oqi      <= oqi_nxt;
            oe       <= oe_nxt;
            ie       <= ie_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
        end
    end

    // Next-state, counter and shift-register logic; a start bit wins over TX
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        turn_cnt_nxt = turn_cnt;
        shreg_nxt    = shreg;
        case (state)
            S_IDLE: begin
                if (iz_s) begin
                    state_nxt   = S_RX;
                    bit_cnt_nxt = '0;
                end else if (bus.tx_valid) begin
                    state_nxt   = S_TX;
                    bit_cnt_nxt = '0;
                    shreg_nxt   = bus.tx_data;
                end
            end
            S_TX: begin
                if (bit_cnt == TX_LAST) begin
                    state_nxt    = S_TURN;
                    turn_cnt_nxt = TURN_INIT;
                end else begin
                    shreg_nxt   = {shreg[WIDTH-2:0], 1'b0};
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            S_RX: begin
                shreg_nxt = {shreg[WIDTH-2:0], iz_s};
                if (bit_cnt == RX_LAST) begin
                    state_nxt    = S_TURN;
                    turn_cnt_nxt = TURN_INIT;
                end else begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                end
            end
            default: begin
                if (turn_cnt <= 4'd1) begin
                    state_nxt = S_IDLE;
                end else begin
                    turn_cnt_nxt = turn_cnt - 4'd1;
                end
            end
        endcase
    end

    // Pad controls follow the upcoming state, so OE and IE can never overlap
    always_comb begin
        oe_nxt       = (state_nxt == S_TX);
        ie_nxt       = (state_nxt == S_IDLE) || (state_nxt == S_RX);
        oqi_nxt      = 1'b0;
        if (state_nxt == S_TX) begin
            oqi_nxt = (state == S_IDLE) ? 1'b1 : shreg[WIDTH-1];
        end
        rx_valid_nxt = (state == S_RX) && (state_nxt == S_TURN);
        rx_data_nxt  = rx_valid_nxt ? shreg_nxt : rx_data;
    end

    assign bus.tx_ready = (state == S_IDLE) && !iz_s;
    assign bus.busy     = (state != S_IDLE);
    assign bus.oqi      = oqi;
    assign bus.oe       = oe;
    assign bus.ie       = ie;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;

endmodule
`default_nettype wire

// File: doc/sdiomux_hdx_serdes.md
Name: sdiomux_hdx_serdes

Overview:
- Half-duplex single-wire serializer/deserializer that sits directly upstream of the SDIOMUX pad cell.
- Drives the pad cell's OQI/OE/IE and consumes its IZ.
- Converts parallel words from fabric logic into a framed serial stream on one bidirectional pad and deserializes incoming frames.
- Enforces bus-turnaround dead cycles so the pad never drives while input is enabled.

Parameters:
- WIDTH, 8, data bits per frame (legal 2..32).
- TURNAROUND, 2, dead cycles with OE=0 and IE=0 after every frame (legal 1..15).
- SYNC_STAGES, 2, flops on IZ before use (legal 2..4).

Ports:
- CLK  input  1  single clock; all state on rising edge.
- RSTN  input  1  synchronous reset, active-low.
- TX_DATA  input  WIDTH  word to transmit.
- TX_VALID  input  1  TX_DATA valid.
- TX_READY  output  1  word accepted when TX_VALID&TX_READY.
- RX_DATA  output  WIDTH  last received word, held until next.
- RX_VALID  output  1  one-cycle pulse: RX_DATA updated.
- BUSY  output  1  state != IDLE.
- OQI  output  1  to SDIOMUX OQI (pad output data).
- OE  output  1  to SDIOMUX OE (pad output enable).
- IE  output  1  to SDIOMUX IE (pad input enable).
- IZ  input  1  from SDIOMUX IZ (pad input data, asynchronous).

Behaviour:
- Frame format: line idles low; 1 start bit (=1), then WIDTH data bits MSB first, one bit per CLK.
- IZ passes through SYNC_STAGES flops -> iz_s. Only iz_s is used.
- OQI, OE, IE, RX_DATA, RX_VALID are registered. TX_READY and BUSY are combinational from state/iz_s.
- States:
  - IDLE: OE=0, IE=1, OQI=0.
  - TX: OE=1, IE=0.
  - RX: OE=0, IE=1.
  - TURN: OE=0, IE=0, OQI=0.
- Reset (RSTN=0 at edge): state=TURN, turn counter=TURNAROUND, bit counter=0, OQI=0, OE=0, IE=0, RX_DATA=0, RX_VALID=0, sync flops=0. Reset mid-frame aborts the frame immediately: no RX_VALID, no further pad drive.
- TX_READY = (state==IDLE) & ~iz_s.
- IDLE -> TX on TX_VALID&TX_READY at edge T:
  - Capture TX_DATA.
  - OE=1, OQI=1 (start bit) in cycle T+1.
  - Data bit WIDTH-1-k in cycle T+2+k.
  - OE=0 from cycle T+2+WIDTH, state TURN.
- IDLE -> RX when iz_s==1 (start detected):
  - Takes precedence over TX_VALID in the same cycle; TX_READY is already 0.
  - Next WIDTH cycles shift iz_s into RX shift register, MSB first.
  - Cycle after the last sample: RX_DATA=shift value, RX_VALID=1 for exactly one cycle, state TURN.
  - Pad-to-RX_VALID latency = SYNC_STAGES+WIDTH+1 cycles from the start bit at IZ.
- TURN: counts TURNAROUND cycles, then IDLE; IE rises on the first IDLE cycle.
- OE and IE are never both 1 in any cycle. OE 1->0 and IE 0->1 are separated by ≥TURNAROUND cycles.
- No RX backpressure: a new frame overwrites RX_DATA; consumer must take it on the RX_VALID pulse.
- TX_VALID held during RX/TX/TURN is not accepted until IDLE; TX_DATA may change freely while TX_READY=0.
- Counters: bit counter $clog2(WIDTH+1) bits, turn counter 4 bits; neither wraps.
- A start bit arriving during TX or TURN is ignored. After TURN, a still-high iz_s is treated as a new start bit.

Test Plan:
- Reset release (WIDTH=8, TURNAROUND=2, SYNC=2): RSTN low 3 cycles then high -> OE=0, IE=0 for 2 cycles, then IE=1, TX_READY=1, BUSY=0, RX_VALID never pulses.
- TX 0xA5 accepted at edge T -> OE=1 cycles T+1..T+9; OQI=1,1,0,1,0,0,1,0,1; OE=0 at T+10; IE=1 and TX_READY=1 at T+12.
- IZ driven 1 then 0x3C MSB-first starting cycle R -> RX_DATA=0x3C, RX_VALID=1 only in cycle R+11, OE=0 throughout.
- TX_VALID asserted in the same cycle iz_s first goes 1 -> no TX acceptance, RX completes, then TX 0x5A sent after TURN with correct OQI sequence.
- RSTN low at bit 4 of TX 0xFF -> OE=0 next cycle, no further OQI=1, standard reset sequence follows.
- Back-to-back RX frames 0x01 then 0x80 separated by TURNAROUND idle cycles -> two RX_VALID pulses, RX_DATA 0x01 then 0x80; OE&IE==0 in every cycle.
